regfile_scoreboard: RTL and testbench

Hazard scoreboard for the 64-bit, 32-entry pipeline register file. Tracks registers with an outstanding memory load and stalls the issue stage when an instruction would read or overwrite a register whose load data has not returned. Sits between decode/issue and the register file. Consumes the same read-address and load-writeback signals the register file uses, so forwarding of same-cycle load data is honoured.

---
 rtl/regfile_scoreboard.sv | 88 ++++++++
 tb/tb_regfile_scoreboard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Load-use hazard scoreboard for the 32-entry register file: tracks registers with
// an outstanding load and stalls issue on RAW/WAW/capacity hazards.
module regfile_scoreboard #(
  parameter int MAX_LOADS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        issue_valid,
  input  logic        read_n_sp,
  input  logic [4:0]  issue_rn,
  input  logic [4:0]  issue_rm,
  input  logic [4:0]  issue_ra,
  input  logic        use_n,
  input  logic        use_m,
  input  logic        use_a,
  input  logic [4:0]  issue_rd,
  input  logic        use_d,
  input  logic        issue_is_load,
  input  logic        wload_en,
  input  logic [4:0]  wload_reg_a,
  output logic        stall,
  output logic        issue_fire,
  output logic [30:0] pending,
  output logic [3:0]  load_count,
  output logic        sb_err
);

  logic [30:0] pending_reg, pending_next;
  logic [3:0]  count_reg, count_next;
  logic        err_reg, err_next;

  logic [30:0] clr_vec, set_vec, eff;
  logic [31:0] eff32, pending32;
  logic        wload_ok, clr_valid;
  logic        haz_src, haz_waw, haz_cap;
  logic        unused_sp;

  // SP and XZR are never load targets, so index 31 needs no tracking.
  assign unused_sp = read_n_sp;

  assign wload_ok = wload_en & (wload_reg_a != 5'd31);

  generate
    for (genvar gi = 0; gi < 31; gi++) begin : g_vec
      assign clr_vec[gi] = wload_ok & (wload_reg_a == 5'(gi));
      assign set_vec[gi] = issue_fire & use_d & issue_is_load & (issue_rd == 5'(gi));
    end
  endgenerate

  // A returning load is forwarded by the register file, so it no longer blocks.
  assign eff       = pending_reg & ~clr_vec;
  assign eff32     = {1'b0, eff};
  assign pending32 = {1'b0, pending_reg};
  assign clr_valid = |(clr_vec & pending_reg);

  assign haz_src = (use_n & eff32[issue_rn]) |
                   (use_m & eff32[issue_rm]) |
                   (use_a & eff32[issue_ra]);
  assign haz_waw = use_d & eff32[issue_rd];
  assign haz_cap = use_d & issue_is_load & (count_reg == 4'(MAX_LOADS)) & ~wload_ok;

  assign stall      = issue_valid & (haz_src | haz_waw | haz_cap);
  assign issue_fire = issue_valid & ~stall & clk_en;

  always_comb begin
    pending_next = (pending_reg & ~clr_vec) | set_vec;
    count_next   = count_reg + {3'b000, |set_vec} - {3'b000, clr_valid};
    err_next     = err_reg | (wload_en & ~pending32[wload_reg_a]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
    end else if (clk_en) begin
      pending_reg <= pending_next;
      count_reg   <= count_next;
      err_reg     <= err_next;
    end
  end

  assign pending    = pending_reg;
  assign load_count = count_reg;
  assign sb_err     = err_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard against a register-array
// reference model of the hazard and bookkeeping rules.
module tb_regfile_scoreboard;
  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        rst, clk_en, issue_valid, read_n_sp;
  logic [4:0]  issue_rn, issue_rm, issue_ra, issue_rd, wload_reg_a;
  logic        use_n, use_m, use_a, use_d, issue_is_load, wload_en;
  logic        stall, issue_fire, sb_err;
  logic [30:0] pending;
  logic [3:0]  load_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic obs_stall, obs_fire;

  // Reference state: one flag per register, an integer count, a sticky error.
  bit m_pend[31];
  int m_count;
  bit m_err;

  regfile_scoreboard #(.MAX_LOADS(MAXL)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .issue_valid(issue_valid),
    .read_n_sp(read_n_sp), .issue_rn(issue_rn), .issue_rm(issue_rm),
    .issue_ra(issue_ra), .use_n(use_n), .use_m(use_m), .use_a(use_a),
    .issue_rd(issue_rd), .use_d(use_d), .issue_is_load(issue_is_load),
    .wload_en(wload_en), .wload_reg_a(wload_reg_a), .stall(stall),
    .issue_fire(issue_fire), .pending(pending), .load_count(load_count),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit blocked(input int r);
    int ret;
    ret = (wload_en && wload_reg_a != 31) ? int'(wload_reg_a) : -1;
    return (r < 31) && m_pend[r] && (r != ret);
  endfunction

  function automatic bit model_stall();
    bit hz;
    bit ret_any;
    ret_any = wload_en && (wload_reg_a != 31);
    hz = (use_n && blocked(issue_rn)) || (use_m && blocked(issue_rm)) ||
         (use_a && blocked(issue_ra)) || (use_d && blocked(issue_rd)) ||
         (use_d && issue_is_load && m_count == MAXL && !ret_any);
    return issue_valid && hz;
  endfunction

  function automatic logic [30:0] model_vec();
    logic [30:0] v;
    for (int i = 0; i < 31; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_update(input bit fire);
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_count = 0;
      m_err = 0;
    end else if (clk_en) begin
      if (wload_en) begin
        if (wload_reg_a == 31 || !m_pend[wload_reg_a]) m_err = 1;
        else begin
          m_pend[wload_reg_a] = 0;
          m_count--;
        end
      end
      if (fire && use_d && issue_is_load && issue_rd != 31) begin
        m_pend[issue_rd] = 1;
        m_count++;
      end
    end
  endtask

  task automatic idle();
    rst = 0; clk_en = 1; issue_valid = 0; read_n_sp = 0;
    issue_rn = 0; issue_rm = 0; issue_ra = 0; issue_rd = 0;
    use_n = 0; use_m = 0; use_a = 0; use_d = 0; issue_is_load = 0;
    wload_en = 0; wload_reg_a = 0;
  endtask

  task automatic load(input int rd);
    idle(); issue_valid = 1; use_d = 1; issue_is_load = 1; issue_rd = 5'(rd);
  endtask

  // One clock cycle: check combinational outputs, clock, check registered state.
  task automatic cycle();
    bit es, ef;
    #2;
    es = model_stall();
    ef = issue_valid && !es && clk_en;
    obs_stall = stall;
    obs_fire = issue_fire;
    chk("stall", {31'b0, stall}, {31'b0, es});
    chk("issue_fire", {31'b0, issue_fire}, {31'b0, ef});
    @(posedge clk);
    model_update(ef);
    #1;
    chk("pending", {1'b0, pending}, {1'b0, model_vec()});
    chk("load_count", {28'b0, load_count}, 32'(m_count));
    chk("sb_err", {31'b0, sb_err}, {31'b0, m_err});
    $display("cyc %0d v=%0b ld=%0b rd=%0d wl=%0b/%0d stall=%0b fire=%0b pend=%08h cnt=%0d err=%0b",
             cyc, issue_valid, issue_is_load, issue_rd, wload_en, wload_reg_a,
             obs_stall, obs_fire, pending, load_count, sb_err);
    cyc++;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    int q[$];
    idle();
    rst = 1;
    @(posedge clk); #1;
    model_update(1'b0);
    chk("reset_pending", {1'b0, pending}, 32'd0);
    chk("reset_count", {28'b0, load_count}, 32'd0);
    chk("reset_err", {31'b0, sb_err}, 32'd0);

    // 1: ALU ops reading every register with nothing pending
    for (int i = 0; i < 31; i++) begin
      idle(); issue_valid = 1; use_n = 1; use_m = 1; use_a = 1; use_d = 1;
      issue_rn = 5'(i); issue_rm = 5'(30 - i); issue_ra = 5'(i); issue_rd = 5'(i);
      cycle();
      chk("alu_fire", {31'b0, obs_fire}, 32'd1);
    end

    // 2: RAW on X5, released in the cycle its data returns
    load(5); cycle();
    idle(); issue_valid = 1; use_n = 1; issue_rn = 5; cycle();
    chk("raw_stall", {31'b0, obs_stall}, 32'd1);
    chk("raw_pend5", {31'b0, pending[5]}, 32'd1);
    idle(); issue_valid = 1; use_n = 1; issue_rn = 5; wload_en = 1; wload_reg_a = 5; cycle();
    chk("raw_fwd_fire", {31'b0, obs_fire}, 32'd1);
    chk("raw_pend5_clr", {31'b0, pending[5]}, 32'd0);

    // 3: WAW on X7, load to XZR, SP read
    load(7); cycle();
    idle(); issue_valid = 1; use_d = 1; issue_rd = 7; cycle();
    chk("waw_stall", {31'b0, obs_stall}, 32'd1);
    load(31); cycle();
    chk("xzr_load_count", {28'b0, load_count}, 32'd1);
    idle(); issue_valid = 1; use_n = 1; issue_rn = 31; read_n_sp = 1; cycle();
    chk("sp_read_fire", {31'b0, obs_fire}, 32'd1);
    idle(); wload_en = 1; wload_reg_a = 7; cycle();

    // 4: capacity
    for (int i = 1; i <= 4; i++) begin load(i); cycle(); end
    chk("cap_count4", {28'b0, load_count}, 32'd4);
    load(9); cycle();
    chk("cap_stall", {31'b0, obs_stall}, 32'd1);
    load(9); wload_en = 1; wload_reg_a = 2; cycle();
    chk("cap_swap_fire", {31'b0, obs_fire}, 32'd1);
    chk("cap_swap_count", {28'b0, load_count}, 32'd4);
    chk("cap_swap_pend", {1'b0, pending}, 32'h0000_021A);

    // 5: X3 completes and is reloaded in the same cycle
    load(3); wload_en = 1; wload_reg_a = 3; cycle();
    chk("reload_fire", {31'b0, obs_fire}, 32'd1);
    chk("reload_pend3", {31'b0, pending[3]}, 32'd1);
    chk("reload_count", {28'b0, load_count}, 32'd4);

    // 6: spurious writeback and frozen clock enable
    idle(); wload_en = 1; wload_reg_a = 12; cycle();
    chk("err_set", {31'b0, sb_err}, 32'd1);
    chk("err_count", {28'b0, load_count}, 32'd4);
    idle(); cycle();
    chk("err_sticky", {31'b0, sb_err}, 32'd1);
    idle(); wload_en = 1; wload_reg_a = 1; cycle();
    load(20); clk_en = 0; wload_en = 1; wload_reg_a = 3; cycle();
    chk("cken_fire", {31'b0, obs_fire}, 32'd0);
    chk("cken_count", {28'b0, load_count}, 32'd3);
    idle(); rst = 1; cycle();
    chk("err_rst", {31'b0, sb_err}, 32'd0);

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      idle();
      rst         = ($urandom_range(0, 99) < 2);
      clk_en      = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1);
      read_n_sp   = $urandom_range(0, 1);
      use_n = $urandom_range(0, 1); use_m = $urandom_range(0, 1);
      use_a = $urandom_range(0, 1); use_d = $urandom_range(0, 1);
      issue_is_load = $urandom_range(0, 1);
      issue_rn = rnd_reg(); issue_rm = rnd_reg(); issue_ra = rnd_reg(); issue_rd = rnd_reg();
      q.delete();
      foreach (m_pend[i]) if (m_pend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        wload_en = 1;
        wload_reg_a = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
